// File: rtl/mac_accum_requant.sv
// Accumulates MAC tree results per packet, then requantizes each total (shift + saturate) into an output FIFO.
// Latency: one-beat packet accepted in cycle t gives out_valid from cycle t+MAC_LATENCY+1 (FIFO empty).
// Backpressure: mac_ready_out credits FIFO space against packet ends in flight; out_data held while !out_ready.
module mac_accum_requant #(
  parameter int ACC_WIDTH    = 32,
  parameter int OUTPUT_WIDTH = 16,
  parameter int OUT_SHIFT    = 8,
  parameter int MAC_LATENCY  = 3,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst_in,
  input  logic                    mac_valid_in,
  input  logic                    mac_first_in,
  input  logic                    mac_last_in,
  output logic                    mac_ready_out,
  input  logic [ACC_WIDTH-1:0]    mac_result_in,
  output logic [OUTPUT_WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy_out
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int IW = $clog2(MAC_LATENCY + 1);
  localparam int KW = ((CW > IW) ? CW : IW) + 1;

  // Delay line tracking beats through the MAC tree; index MAC_LATENCY-1 is the tail.
  logic [MAC_LATENCY-1:0] dl_vld_q, dl_vld_d;
  logic [MAC_LATENCY-1:0] dl_first_q, dl_first_d;
  logic [MAC_LATENCY-1:0] dl_last_q, dl_last_d;

  logic [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic                    open_q, open_d;

  logic [OUTPUT_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;

  logic                    accept;
  logic                    consume;
  logic                    push;
  logic                    pop;
  logic [IW-1:0]           inflight;
  logic [ACC_WIDTH-1:0]    base;
  logic [ACC_WIDTH:0]      sum_wide;
  logic [ACC_WIDTH-1:0]    sum_sat;
  logic signed [ACC_WIDTH-1:0] shifted;
  logic [ACC_WIDTH-OUTPUT_WIDTH:0] shifted_hi;
  logic [OUTPUT_WIDTH-1:0] requant;

  // Credit: FIFO occupancy plus packet ends still in the MAC; a same-cycle pop is deliberately ignored.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MAC_LATENCY; i++) begin
      inflight = inflight + IW'(dl_vld_q[i] & dl_last_q[i]);
    end
  end

  assign mac_ready_out = (KW'(count_q) + KW'(inflight)) < KW'(FIFO_DEPTH);
  assign accept        = mac_valid_in & mac_ready_out;
  assign consume       = dl_vld_q[MAC_LATENCY-1];
  assign out_valid     = (count_q != '0);
  assign pop           = out_valid & out_ready;
  assign out_data      = out_valid ? mem_q[rd_ptr_q] : '0;
  assign busy_out      = (|dl_vld_q) | open_q | out_valid;

  // Shift accepted beat tags along the delay line.
  always_comb begin
    dl_vld_d      = '0;
    dl_first_d    = '0;
    dl_last_d     = '0;
    dl_vld_d[0]   = accept;
    dl_first_d[0] = mac_first_in;
    dl_last_d[0]  = mac_last_in;
    for (int i = 1; i < MAC_LATENCY; i++) begin
      dl_vld_d[i]   = dl_vld_q[i-1];
      dl_first_d[i] = dl_first_q[i-1];
      dl_last_d[i]  = dl_last_q[i-1];
    end
  end

  // Saturating accumulate of the tail beat, then arithmetic shift and clamp for the packet result.
  always_comb begin
    base     = dl_first_q[MAC_LATENCY-1] ? '0 : acc_q;
    sum_wide = {base[ACC_WIDTH-1], base} + {mac_result_in[ACC_WIDTH-1], mac_result_in};
    if (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1]) begin
      sum_sat = sum_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end else begin
      sum_sat = sum_wide[ACC_WIDTH-1:0];
    end
    shifted    = $signed(sum_sat) >>> OUT_SHIFT;
    shifted_hi = shifted[ACC_WIDTH-1:OUTPUT_WIDTH-1];
    if ((&shifted_hi) || !(|shifted_hi)) begin
      requant = shifted[OUTPUT_WIDTH-1:0];
    end else begin
      requant = shifted[ACC_WIDTH-1] ? {1'b1, {(OUTPUT_WIDTH-1){1'b0}}} : {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
    end
  end

  // Packet state and FIFO pointer next-state.
  always_comb begin
    acc_d  = acc_q;
    open_d = open_q;
    push   = 1'b0;
    if (consume) begin
      if (dl_last_q[MAC_LATENCY-1]) begin
        acc_d  = '0;
        open_d = 1'b0;
        push   = 1'b1;
      end else begin
        acc_d  = sum_sat;
        open_d = 1'b1;
      end
    end
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      dl_vld_q   <= '0;
      dl_first_q <= '0;
      dl_last_q  <= '0;
      acc_q      <= '0;
      open_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      dl_vld_q   <= dl_vld_d;
      dl_first_q <= dl_first_d;
      dl_last_q  <= dl_last_d;
      acc_q      <= acc_d;
      open_q     <= open_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (!rst_in && push) begin
      mem_q[wr_ptr_q] <= requant;
    end
  end

  // The credit check must make a push into a full FIFO impossible.
  always_ff @(posedge clk) begin
    if (!rst_in) begin
      assert (!(push && !pop && (count_q == CW'(FIFO_DEPTH))));
    end
  end

endmodule
